fb_write_scheduler: RTL and testbench

//  Arbitrates the single write port of the 12-bit frame buffer (RAM_2Port, 76800 x 12).

---
 rtl/fb_write_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_fb_write_scheduler.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_write_scheduler.sv
// fb_write_scheduler
//   Arbitrates the single write port of the 12-bit frame buffer between the
//   camera capture stream, a host/overlay writer and an internal clear engine.
//   Priority is capture > host > clear. A starvation counter forces one host
//   grant after STARVE_LIMIT consecutive host denials.
//
//   Handshake: a requester asserts valid with addr/data and holds all three
//   until it sees ready in the same cycle. The transfer happens when valid and
//   ready are both high, and the write appears on wr_* exactly one cycle later
//   with wr_dv=1. When nothing is written, wr_addr/wr_data keep their last values.
//
//   Optional feature macro: FB_ADDR_CHECK_EN
//     defined   - accepted requests with addr >= DEPTH are dropped (no wr_dv)
//                 and set the sticky addr_err flag.
//     undefined - addresses are forwarded unchanged and addr_err is tied to 0.
module fb_write_scheduler #(
  parameter int                WIDTH        = 12,
  parameter int                DEPTH        = 76800,
  parameter int                AW           = $clog2(DEPTH),
  parameter int                STARVE_LIMIT = 8,
  parameter logic [WIDTH-1:0]  CLEAR_COLOR  = 12'h000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cap_valid,
  output logic             cap_ready,
  input  logic [AW-1:0]    cap_addr,
  input  logic [WIDTH-1:0] cap_data,
  input  logic             host_valid,
  output logic             host_ready,
  input  logic [AW-1:0]    host_addr,
  input  logic [WIDTH-1:0] host_data,
  input  logic             clear_start,
  output logic             clear_busy,
  output logic             clear_done,
  output logic [AW-1:0]    wr_addr,
  output logic             wr_dv,
  output logic [WIDTH-1:0] wr_data,
  output logic             addr_err
);

  // Counter wide enough to hold STARVE_LIMIT itself (it saturates there).
  localparam int             SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]  STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [AW-1:0]  LAST_ADDR  = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } clr_state_e;

  clr_state_e       state_q, state_d;
  logic [AW-1:0]    clr_addr_q, clr_addr_d;
  logic [SW-1:0]    starve_cnt_q, starve_cnt_d;
  logic             wr_dv_q, wr_dv_d;
  logic [AW-1:0]    wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;

  logic             force_host;
  logic             cap_acc;
  logic             host_acc;
  logic             clr_wr;
  logic             req_acc;
  logic [AW-1:0]    req_addr;
  logic [WIDTH-1:0] req_data;
  logic             req_bad;

  // Per-cycle arbitration: capture first unless the host is being forced in;
  // the clear engine only gets cycles that neither requester takes.
  always_comb begin
    force_host = (starve_cnt_q == STARVE_MAX);
    cap_ready  = cap_valid & ~force_host;
    host_ready = host_valid & (~cap_valid | force_host);
    cap_acc    = cap_valid & cap_ready;
    host_acc   = host_valid & host_ready;
    clr_wr     = (state_q == ST_CLEAR) & ~cap_acc & ~host_acc;
  end

  // Select the accepted request (at most one of cap_acc/host_acc is high).
  always_comb begin
    req_acc  = cap_acc | host_acc;
    req_addr = cap_acc ? cap_addr : host_addr;
    req_data = cap_acc ? cap_data : host_data;
  end

  // Count consecutive host denials; any grant or idle host restarts the count.
  always_comb begin
    starve_cnt_d = '0;
    if (host_valid && !host_acc) begin
      starve_cnt_d = (starve_cnt_q == STARVE_MAX) ? starve_cnt_q : starve_cnt_q + 1'b1;
    end
  end

`ifdef FB_ADDR_CHECK_EN
  localparam int            AW1     = AW + 1;
  localparam logic [AW:0]   DEPTH_W = AW1'(DEPTH);

  logic addr_err_q, addr_err_d;

  // An accepted request beyond the buffer is swallowed and flagged.
  always_comb begin
    req_bad    = req_acc & ({1'b0, req_addr} >= DEPTH_W);
    addr_err_d = addr_err_q | req_bad;
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_err_q <= 1'b0;
    end else begin
      addr_err_q <= addr_err_d;
    end
  end

  assign addr_err = addr_err_q;
`else
  assign req_bad  = 1'b0;
  assign addr_err = 1'b0;
`endif

  // Next write on the RAM port: accepted request first, else a clear word.
  always_comb begin
    wr_dv_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (req_acc) begin
      if (!req_bad) begin
        wr_dv_d   = 1'b1;
        wr_addr_d = req_addr;
        wr_data_d = req_data;
      end
    end else if (clr_wr) begin
      wr_dv_d   = 1'b1;
      wr_addr_d = clr_addr_q;
      wr_data_d = CLEAR_COLOR;
    end
  end

  // Clear engine: walks 0..DEPTH-1 on spare cycles, then spends one cycle in
  // DONE so clear_done lines up with the registered last clear write.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_start) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
        end
      end
      ST_CLEAR: begin
        if (clr_wr) begin
          if (clr_addr_q == LAST_ADDR) begin
            state_d = ST_DONE;
          end else begin
            clr_addr_d = clr_addr_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and the registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      clr_addr_q   <= '0;
      starve_cnt_q <= '0;
      wr_dv_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      starve_cnt_q <= starve_cnt_d;
      wr_dv_q      <= wr_dv_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign clear_busy = (state_q != ST_IDLE);
  assign clear_done = (state_q == ST_DONE);
  assign wr_dv      = wr_dv_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Bench for fb_write_scheduler, built with a reduced DEPTH so full clears
// stay short. A queue-based behavioural model predicts every output each
// cycle; directed sections pin the model with hand-computed values.
module tb_fb_write_scheduler;

  localparam int               WIDTH     = 12;
  localparam int               DEPTH     = 2000;
  localparam int               AW        = $clog2(DEPTH);
  localparam int               LIMIT     = 8;
  localparam logic [WIDTH-1:0] CLR_COLOR = 12'h000;
  localparam int               EW        = 1 + AW + WIDTH;

`ifdef FB_ADDR_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cap_valid = 1'b0;
  logic [AW-1:0]    cap_addr = '0;
  logic [WIDTH-1:0] cap_data = '0;
  logic             host_valid = 1'b0;
  logic [AW-1:0]    host_addr = '0;
  logic [WIDTH-1:0] host_data = '0;
  logic             clear_start = 1'b0;
  logic             cap_ready, host_ready, clear_busy, clear_done, wr_dv, addr_err;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;

  always #5 clk = ~clk;

  fb_write_scheduler #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT), .CLEAR_COLOR(CLR_COLOR)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cap_valid(cap_valid), .cap_ready(cap_ready), .cap_addr(cap_addr), .cap_data(cap_data),
    .host_valid(host_valid), .host_ready(host_ready), .host_addr(host_addr), .host_data(host_data),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
    .wr_addr(wr_addr), .wr_dv(wr_dv), .wr_data(wr_data), .addr_err(addr_err)
  );

  // ---------------- checking helpers ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Outcome of the arbitration at each edge, plus where the clear has got to.
  int               m_starve   = 0;   // consecutive host refusals so far
  int               m_phase    = 0;   // 0 idle, 1 clearing, 2 finishing
  int               m_clr_addr = 0;   // next address the clear will fill
  bit               m_err      = 0;
  bit               m_cap_acc  = 0;
  bit               m_host_acc = 0;
  logic [AW-1:0]    m_last_addr = '0;
  logic [WIDTH-1:0] m_last_data = '0;
  logic [EW-1:0]    exp_q[$];

  always @(posedge clk or negedge rst_n) begin : model
    bit               c_acc, h_acc, clr_wr, dv;
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] d;
    if (!rst_n) begin
      m_starve = 0; m_phase = 0; m_clr_addr = 0; m_err = 0;
      m_cap_acc = 0; m_host_acc = 0;
      m_last_addr = '0; m_last_data = '0;
      exp_q.delete();
    end else begin
      // Capture wins unless the host has already been refused LIMIT times;
      // the host gets the port whenever capture does not take it.
      c_acc  = cap_valid && (m_starve != LIMIT);
      h_acc  = host_valid && !c_acc;
      clr_wr = (m_phase == 1) && !c_acc && !h_acc;
      m_cap_acc  = c_acc;
      m_host_acc = h_acc;
      if (host_valid && !h_acc) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
      else                      m_starve = 0;
      dv = 1'b0;
      if (c_acc || h_acc) begin
        a = c_acc ? cap_addr : host_addr;
        d = c_acc ? cap_data : host_data;
        if (CHECK_EN && int'(a) >= DEPTH) begin
          m_err = 1'b1;
        end else begin
          dv = 1'b1; m_last_addr = a; m_last_data = d;
        end
      end else if (clr_wr) begin
        dv = 1'b1; m_last_addr = AW'(m_clr_addr); m_last_data = CLR_COLOR;
      end
      exp_q.push_back({dv, m_last_addr, m_last_data});
      if (m_phase == 0) begin
        if (clear_start) begin m_phase = 1; m_clr_addr = 0; end
      end else if (m_phase == 1) begin
        if (clr_wr) begin
          if (m_clr_addr == DEPTH - 1) m_phase = 2;
          else m_clr_addr = m_clr_addr + 1;
        end
      end else begin
        m_phase = 0;
      end
    end
  end

  // ---------------- scoreboard compare (every cycle, on the falling edge) ----------------
  logic             e_dv = 1'b0;
  logic [AW-1:0]    e_addr = '0;
  logic [WIDTH-1:0] e_data = '0;

  always @(negedge clk) begin : compare
    bit e_cap, e_host;
    if (!rst_n) begin
      e_dv = 1'b0; e_addr = '0; e_data = '0;
      check("rst_wr_dv", wr_dv, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_clear_busy", clear_busy, 0);
      check("rst_clear_done", clear_done, 0);
      check("rst_addr_err", addr_err, 0);
    end else begin
      if (exp_q.size() > 0) {e_dv, e_addr, e_data} = exp_q.pop_front();
      else e_dv = 1'b0;
      e_cap  = cap_valid && (m_starve != LIMIT);
      e_host = host_valid && !e_cap;
      check("sb_wr_dv", wr_dv, e_dv);
      check("sb_wr_addr", wr_addr, e_addr);
      check("sb_wr_data", wr_data, e_data);
      check("sb_cap_ready", cap_ready, e_cap);
      check("sb_host_ready", host_ready, e_host);
      check("sb_clear_busy", clear_busy, m_phase != 0);
      check("sb_clear_done", clear_done, m_phase == 2);
      check("sb_addr_err", addr_err, m_err);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      cap_valid = 1'b0; host_valid = 1'b0; clear_start = 1'b0;
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 19) == 0) return AW'($urandom_range(DEPTH, (1 << AW) - 1));
    return AW'($urandom_range(0, DEPTH - 1));
  endfunction

  // Random traffic; a refused requester keeps valid/addr/data unchanged.
  task automatic rand_cycles(input int n, input int pct, input int clr_pm);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (!cap_valid || m_cap_acc) begin
        cap_valid = ($urandom_range(0, 99) < pct);
        cap_addr  = rand_addr();
        cap_data  = WIDTH'($urandom);
      end
      if (!host_valid || m_host_acc) begin
        host_valid = ($urandom_range(0, 99) < pct);
        host_addr  = rand_addr();
        host_data  = WIDTH'($urandom);
      end
      clear_start = ($urandom_range(0, 999) < clr_pm);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #(60000 * 10);
    errors++;
    $display("FAIL watchdog: cycle budget exceeded at t=%0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin : stim
    int  denials, n_wr, bad_addr, done_at, post_wr, post_busy;
    bit  granted, done_seen, found;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_wr_dv", wr_dv, 0);
    check("reset_cap_ready", cap_ready, 0);
    check("reset_host_ready", host_ready, 0);
    check("reset_clear_busy", clear_busy, 0);
    check("reset_addr_err", addr_err, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    idle(3);

    // Single capture write, one-cycle latency
    @(posedge clk); #1;
    cap_valid = 1'b1; cap_addr = AW'(5); cap_data = 12'hABC;
    @(negedge clk); check("single_cap_ready", cap_ready, 1);
    @(posedge clk); #1; cap_valid = 1'b0;
    @(negedge clk);
    check("single_wr_dv", wr_dv, 1);
    check("single_wr_addr", wr_addr, 5);
    check("single_wr_data", wr_data, 12'hABC);
    idle(3);

    // Starvation guard: both held high
    @(posedge clk); #1;
    cap_valid = 1'b1; cap_addr = AW'(10); cap_data = 12'h111;
    host_valid = 1'b1; host_addr = AW'(20); host_data = 12'h222;
    denials = 0; granted = 1'b0;
    for (int i = 0; i < 20 && !granted; i++) begin
      @(negedge clk);
      if (host_ready) granted = 1'b1;
      else denials++;
    end
    check("starve_granted", granted, 1);
    check("starve_denials", denials, LIMIT);
    check("starve_cap_held_off", cap_ready, 0);
    @(posedge clk); #1; host_valid = 1'b0;
    @(negedge clk);
    check("starve_host_write_addr", wr_addr, 20);
    check("starve_host_write_data", wr_data, 12'h222);
    check("starve_cap_resumes", cap_ready, 1);
    idle(3);

    // Full clear with no traffic
    @(posedge clk); #1; clear_start = 1'b1;
    @(posedge clk); #1; clear_start = 1'b0;
    n_wr = 0; bad_addr = 0; done_seen = 1'b0; done_at = -1;
    for (int i = 0; i < DEPTH + 20 && !done_seen; i++) begin
      @(negedge clk);
      if (wr_dv) begin
        if (int'(wr_addr) != n_wr || wr_data != CLR_COLOR) bad_addr++;
        n_wr++;
      end
      if (clear_done) begin done_seen = 1'b1; done_at = int'(wr_addr); end
    end
    check("clear_done_seen", done_seen, 1);
    check("clear_write_count", n_wr, DEPTH);
    check("clear_sequence_errors", bad_addr, 0);
    check("clear_done_last_addr", done_at, DEPTH - 1);
    @(negedge clk);
    check("clear_busy_drops", clear_busy, 0);
    idle(3);

    // Out-of-range host write
    @(negedge clk); check("oor_err_before", addr_err, 0);
    @(posedge clk); #1;
    host_valid = 1'b1; host_addr = AW'(DEPTH); host_data = 12'h123;
    @(negedge clk); check("oor_host_ready", host_ready, 1);
    @(posedge clk); #1; host_valid = 1'b0;
    @(negedge clk);
    check("oor_wr_dv", wr_dv, !CHECK_EN);
    check("oor_addr_err", addr_err, CHECK_EN);
    idle(5);
    @(negedge clk); check("oor_addr_err_sticky", addr_err, CHECK_EN);

    // Reset in the middle of a clear
    @(posedge clk); #1; clear_start = 1'b1;
    @(posedge clk); #1; clear_start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < DEPTH + 50 && !found; i++) begin
      @(negedge clk);
      if (wr_dv && int'(wr_addr) == 1000) found = 1'b1;
    end
    check("midclear_reached_1000", found, 1);
    check("midclear_busy_before_reset", clear_busy, 1);
    @(posedge clk); #1; rst_n = 1'b0;
    @(negedge clk);
    check("midclear_busy_in_reset", clear_busy, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    post_wr = 0; post_busy = 0;
    repeat (50) begin
      @(negedge clk);
      if (wr_dv) post_wr++;
      if (clear_busy) post_busy++;
    end
    check("midclear_no_writes_after", post_wr, 0);
    check("midclear_no_busy_after", post_busy, 0);

    // Randomized traffic, mixed with clears
    rand_cycles(3000, 60, 2);
    rand_cycles(1500, 95, 1);
    rand_cycles(4000, 15, 3);
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
